// File: rtl/uart_xcvr_if.sv
// Bundles the UART transceiver's serial lines, TX request/payload and RX results.
// The master side is the system driving the transceiver; the slave side is the transceiver itself.
interface uart_xcvr_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 tx;
  logic [DATA_BITS-1:0] dintx;
  logic                 newd;
  logic [DATA_BITS-1:0] doutrx;
  logic                 donetx;
  logic                 donerx;
  logic                 tx_busy;
  logic                 perr;
  logic                 ferr;

  modport master (
    output rx, dintx, newd,
    input  tx, doutrx, donetx, donerx, tx_busy, perr, ferr
  );

  modport slave (
    input  rx, dintx, newd,
    output tx, doutrx, donetx, donerx, tx_busy, perr, ferr
  );
endinterface

// File: rtl/uart_xcvr.sv
// Full-duplex UART: independent TX and RX state machines with 16x oversample bit timing,
// optional even/odd parity, 1 or 2 TX stop bits and a two-flop RX synchroniser.
module uart_xcvr #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  uart_xcvr_if.slave  bus
);
  localparam int DIV      = CLK_FREQ / (BAUD_RATE * 16);
  localparam int BIT_CLKS = DIV * 16;
  localparam int CNT_W    = (BIT_CLKS < 2) ? 1 : $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] C_MID  = CNT_W'(DIV * 8);
  localparam logic [2:0] C_LAST_DATA  = 3'(DATA_BITS - 1);
  localparam logic [2:0] C_LAST_STOP  = 3'(STOP_BITS - 1);
  localparam logic       C_ODD        = (PARITY == 2);

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || DIV < 1) begin : g_bad_params
    $fatal(1, "uart_xcvr: illegal parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_tx_state, w_tx_state_nx;
  logic [CNT_W-1:0]     r_tx_cnt, w_tx_cnt_nx;
  logic [2:0]           r_tx_idx, w_tx_idx_nx;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nx;
  logic                 r_tx_par, w_tx_par_nx;
  logic                 r_tx, w_tx_nx;
  logic                 r_donetx, w_donetx_nx;
  logic                 w_tx_busy, w_tx_end;

  assign w_tx_busy = (r_tx_state != S_IDLE) || r_donetx;
  assign w_tx_end  = (r_tx_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
      r_donetx   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_idx   <= w_tx_idx_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_tx_par   <= w_tx_par_nx;
      r_tx       <= w_tx_nx;
      r_donetx   <= w_donetx_nx;
    end
  end

  // The line is registered from the current state, so it trails the state by one clock.
  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt + CNT_W'(1);
    w_tx_idx_nx   = r_tx_idx;
    w_tx_shift_nx = r_tx_shift;
    w_tx_par_nx   = r_tx_par;
    w_tx_nx       = 1'b1;
    w_donetx_nx   = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        w_tx_cnt_nx = '0;
        if (bus.newd && !w_tx_busy) begin
          w_tx_state_nx = S_START;
          w_tx_idx_nx   = '0;
          w_tx_shift_nx = bus.dintx;
          w_tx_par_nx   = (^bus.dintx) ^ C_ODD;
        end
      end
      S_START: begin
        w_tx_nx = 1'b0;
        if (w_tx_end) begin
          w_tx_cnt_nx   = '0;
          w_tx_idx_nx   = '0;
          w_tx_state_nx = S_DATA;
        end
      end
      S_DATA: begin
        w_tx_nx = r_tx_shift[0];
        if (w_tx_end) begin
          w_tx_cnt_nx   = '0;
          w_tx_shift_nx = r_tx_shift >> 1;
          if (r_tx_idx == C_LAST_DATA) begin
            w_tx_idx_nx   = '0;
            w_tx_state_nx = (PARITY == 0) ? S_STOP : S_PARITY;
          end else begin
            w_tx_idx_nx = r_tx_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        w_tx_nx = r_tx_par;
        if (w_tx_end) begin
          w_tx_cnt_nx   = '0;
          w_tx_idx_nx   = '0;
          w_tx_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tx_end) begin
          w_tx_cnt_nx = '0;
          if (r_tx_idx == C_LAST_STOP) begin
            w_tx_state_nx = S_IDLE;
            w_donetx_nx   = 1'b1;
          end else begin
            w_tx_idx_nx = r_tx_idx + 3'd1;
          end
        end
      end
      default: w_tx_state_nx = S_IDLE;
    endcase
  end

  state_t               r_rx_state, w_rx_state_nx;
  logic [CNT_W-1:0]     r_rx_cnt, w_rx_cnt_nx;
  logic [2:0]           r_rx_idx, w_rx_idx_nx;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nx;
  logic                 r_rx_pbit, w_rx_pbit_nx;
  logic [DATA_BITS-1:0] r_doutrx, w_doutrx_nx;
  logic                 r_perr, w_perr_nx;
  logic                 r_ferr, w_ferr_nx;
  logic                 r_donerx, w_donerx_nx;
  logic                 r_rx_s1, r_rx_s2, r_rx_prev;
  logic                 w_rx_fall, w_rx_end;

  // Start detection needs a 1->0 transition, so after a framing error it re-arms only once rx returns high.
  assign w_rx_fall = r_rx_prev & ~r_rx_s2;
  assign w_rx_end  = (r_rx_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_pbit  <= 1'b0;
      r_doutrx   <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_donerx   <= 1'b0;
    end else begin
      r_rx_s1    <= bus.rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_nx;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_idx   <= w_rx_idx_nx;
      r_rx_shift <= w_rx_shift_nx;
      r_rx_pbit  <= w_rx_pbit_nx;
      r_doutrx   <= w_doutrx_nx;
      r_perr     <= w_perr_nx;
      r_ferr     <= w_ferr_nx;
      r_donerx   <= w_donerx_nx;
    end
  end

  // START samples at mid-bit; from then on every full bit period lands on the next mid-bit.
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_cnt_nx   = r_rx_cnt + CNT_W'(1);
    w_rx_idx_nx   = r_rx_idx;
    w_rx_shift_nx = r_rx_shift;
    w_rx_pbit_nx  = r_rx_pbit;
    w_doutrx_nx   = r_doutrx;
    w_perr_nx     = r_perr;
    w_ferr_nx     = r_ferr;
    w_donerx_nx   = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        w_rx_cnt_nx = '0;
        if (w_rx_fall) w_rx_state_nx = S_START;
      end
      S_START: begin
        if (r_rx_cnt == C_MID) begin
          w_rx_cnt_nx   = '0;
          w_rx_idx_nx   = '0;
          w_rx_state_nx = r_rx_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_rx_end) begin
          w_rx_cnt_nx   = '0;
          w_rx_shift_nx = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_idx == C_LAST_DATA) begin
            w_rx_state_nx = (PARITY == 0) ? S_STOP : S_PARITY;
          end else begin
            w_rx_idx_nx = r_rx_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_rx_end) begin
          w_rx_cnt_nx   = '0;
          w_rx_pbit_nx  = r_rx_s2;
          w_rx_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (w_rx_end) begin
          w_rx_cnt_nx   = '0;
          w_doutrx_nx   = r_rx_shift;
          w_perr_nx     = (PARITY != 0) && ((^r_rx_shift) ^ r_rx_pbit ^ C_ODD);
          w_ferr_nx     = ~r_rx_s2;
          w_donerx_nx   = 1'b1;
          w_rx_state_nx = S_IDLE;
        end
      end
      default: w_rx_state_nx = S_IDLE;
    endcase
  end

  assign bus.tx      = r_tx;
  assign bus.tx_busy = w_tx_busy;
  assign bus.donetx  = r_donetx;
  assign bus.doutrx  = r_doutrx;
  assign bus.donerx  = r_donerx;
  assign bus.perr    = r_perr;
  assign bus.ferr    = r_ferr;
endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: three instances (8N1, 8E1, 8O1) share clock, reset,
// TX request/payload and the RX line; each scenario task checks its own expectations.
module tb_uart_xcvr;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_line = 1'b1;
  logic       newd = 1'b0;
  logic [7:0] dintx = 8'h00;

  int checks = 0;
  int errors = 0;
  int n_dtx0 = 0, n_dtx1 = 0, n_dtx2 = 0;
  int n_drx0 = 0, n_drx1 = 0, n_drx2 = 0;

  always #5 clk = ~clk;

  uart_xcvr_if #(.DATA_BITS(8)) if0 ();
  uart_xcvr_if #(.DATA_BITS(8)) if1 ();
  uart_xcvr_if #(.DATA_BITS(8)) if2 ();

  assign if0.rx = rx_line;  assign if0.newd = newd;  assign if0.dintx = dintx;
  assign if1.rx = rx_line;  assign if1.newd = newd;  assign if1.dintx = dintx;
  assign if2.rx = rx_line;  assign if2.newd = newd;  assign if2.dintx = dintx;

  uart_xcvr #(.PARITY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  uart_xcvr #(.PARITY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  uart_xcvr #(.PARITY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  always @(posedge clk) begin
    if (if0.donetx) n_dtx0 <= n_dtx0 + 1;
    if (if1.donetx) n_dtx1 <= n_dtx1 + 1;
    if (if2.donetx) n_dtx2 <= n_dtx2 + 1;
    if (if0.donerx) n_drx0 <= n_drx0 + 1;
    if (if1.donerx) n_drx1 <= n_drx1 + 1;
    if (if2.donerx) n_drx2 <= n_drx2 + 1;
  end

  // Leaves the caller at the negedge after the accepting posedge.
  task automatic pulse_newd(input logic [7:0] d);
    @(negedge clk);
    dintx = d;
    newd  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    newd = 1'b0;
  endtask

  task automatic send_rx(input logic [10:0] bits, input int nbits);
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_line = bits[i];
      repeat (96) @(negedge clk);
    end
    rx_line = 1'b1;
    repeat (192) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (if0.tx !== 1'b1)      begin errors++; $display("FAIL rst_tx got %b exp 1", if0.tx); end
    checks++; if (if0.tx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", if0.tx_busy); end
    checks++; if (if0.donetx !== 1'b0)  begin errors++; $display("FAIL rst_donetx got %b exp 0", if0.donetx); end
    checks++; if (if0.donerx !== 1'b0)  begin errors++; $display("FAIL rst_donerx got %b exp 0", if0.donerx); end
    checks++; if (if0.doutrx !== 8'h00) begin errors++; $display("FAIL rst_doutrx got %h exp 00", if0.doutrx); end
    checks++; if (if0.perr !== 1'b0)    begin errors++; $display("FAIL rst_perr got %b exp 0", if0.perr); end
    checks++; if (if0.ferr !== 1'b0)    begin errors++; $display("FAIL rst_ferr got %b exp 0", if0.ferr); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_tx_8n1;
    logic [9:0] exp;
    int done_k;
    exp    = {1'b1, 8'hA5, 1'b0};
    done_k = -1;
    pulse_newd(8'hA5);
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      if (k >= 49 && ((k - 49) % 96) == 0 && ((k - 49) / 96) < 10) begin
        checks++;
        if (if0.tx !== exp[(k - 49) / 96]) begin
          errors++;
          $display("FAIL tx8n1_bit%0d got %b exp %b", (k - 49) / 96, if0.tx, exp[(k - 49) / 96]);
        end
      end
      if (k == 960) begin
        checks++; if (if0.tx_busy !== 1'b1) begin errors++; $display("FAIL tx8n1_busy_at_done got %b exp 1", if0.tx_busy); end
      end
      if (k == 961) begin
        checks++; if (if0.tx_busy !== 1'b0) begin errors++; $display("FAIL tx8n1_busy_after got %b exp 0", if0.tx_busy); end
      end
      if (if0.donetx && done_k < 0) done_k = k;
    end
    checks++;
    if (done_k !== 960) begin errors++; $display("FAIL tx8n1_donetx_latency got %0d exp 960", done_k); end
  endtask

  task automatic test_tx_parity;
    logic [10:0] exp_e, exp_o;
    int done_e, done_o;
    exp_e  = {1'b1, 1'b1, 8'h07, 1'b0};
    exp_o  = {1'b1, 1'b0, 8'h07, 1'b0};
    done_e = -1;
    done_o = -1;
    pulse_newd(8'h07);
    for (int k = 1; k <= 1150; k++) begin
      @(negedge clk);
      if (k >= 49 && ((k - 49) % 96) == 0 && ((k - 49) / 96) < 11) begin
        checks++;
        if (if1.tx !== exp_e[(k - 49) / 96]) begin
          errors++;
          $display("FAIL txeven_bit%0d got %b exp %b", (k - 49) / 96, if1.tx, exp_e[(k - 49) / 96]);
        end
        checks++;
        if (if2.tx !== exp_o[(k - 49) / 96]) begin
          errors++;
          $display("FAIL txodd_bit%0d got %b exp %b", (k - 49) / 96, if2.tx, exp_o[(k - 49) / 96]);
        end
      end
      if (if1.donetx && done_e < 0) done_e = k;
      if (if2.donetx && done_o < 0) done_o = k;
    end
    checks++; if (done_e !== 1056) begin errors++; $display("FAIL txeven_donetx got %0d exp 1056", done_e); end
    checks++; if (done_o !== 1056) begin errors++; $display("FAIL txodd_donetx got %0d exp 1056", done_o); end
  endtask

  task automatic test_tx_busy_ignore;
    int n0, lows;
    n0   = n_dtx0;
    lows = 0;
    pulse_newd(8'hA5);
    for (int k = 1; k <= 2500; k++) begin
      if (k == 300) begin
        dintx = 8'h00;
        newd  = 1'b1;
      end
      if (k == 302) newd = 1'b0;
      @(negedge clk);
      if (if0.tx === 1'b0) lows++;
    end
    checks++; if (lows !== 480) begin errors++; $display("FAIL busy_tx_low_clocks got %0d exp 480", lows); end
    checks++; if (n_dtx0 - n0 !== 1) begin errors++; $display("FAIL busy_donetx_count got %0d exp 1", n_dtx0 - n0); end
  endtask

  task automatic test_reset_midframe;
    int n0, n1, n2;
    n0 = n_dtx0; n1 = n_dtx1; n2 = n_dtx2;
    pulse_newd(8'hA5);
    repeat (433) @(negedge clk);
    checks++; if (if0.tx !== 1'b0) begin errors++; $display("FAIL rstmid_tx_before got %b exp 0", if0.tx); end
    rst = 1'b0;
    #1;
    checks++; if (if0.tx !== 1'b1)      begin errors++; $display("FAIL rstmid_tx got %b exp 1", if0.tx); end
    checks++; if (if0.tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", if0.tx_busy); end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (1200) @(negedge clk);
    checks++;
    if ((n_dtx0 - n0) + (n_dtx1 - n1) + (n_dtx2 - n2) !== 0) begin
      errors++;
      $display("FAIL rstmid_donetx_count got %0d exp 0", (n_dtx0 - n0) + (n_dtx1 - n1) + (n_dtx2 - n2));
    end
  endtask

  task automatic test_rx_8n1;
    int n0;
    n0 = n_drx0;
    send_rx({1'b0, 1'b1, 8'h3C, 1'b0}, 10);
    checks++; if (n_drx0 - n0 !== 1)    begin errors++; $display("FAIL rx_ok_count got %0d exp 1", n_drx0 - n0); end
    checks++; if (if0.doutrx !== 8'h3C) begin errors++; $display("FAIL rx_ok_data got %h exp 3c", if0.doutrx); end
    checks++; if (if0.perr !== 1'b0)    begin errors++; $display("FAIL rx_ok_perr got %b exp 0", if0.perr); end
    checks++; if (if0.ferr !== 1'b0)    begin errors++; $display("FAIL rx_ok_ferr got %b exp 0", if0.ferr); end
  endtask

  task automatic test_rx_framing;
    int n0;
    n0 = n_drx0;
    send_rx({1'b0, 1'b0, 8'h5A, 1'b0}, 10);
    checks++; if (n_drx0 - n0 !== 1)    begin errors++; $display("FAIL rx_ferr_count got %0d exp 1", n_drx0 - n0); end
    checks++; if (if0.ferr !== 1'b1)    begin errors++; $display("FAIL rx_ferr_flag got %b exp 1", if0.ferr); end
    checks++; if (if0.doutrx !== 8'h5A) begin errors++; $display("FAIL rx_ferr_data got %h exp 5a", if0.doutrx); end
    n0 = n_drx0;
    send_rx({1'b0, 1'b1, 8'h81, 1'b0}, 10);
    checks++; if (n_drx0 - n0 !== 1)    begin errors++; $display("FAIL rx_rearm_count got %0d exp 1", n_drx0 - n0); end
    checks++; if (if0.doutrx !== 8'h81) begin errors++; $display("FAIL rx_rearm_data got %h exp 81", if0.doutrx); end
    checks++; if (if0.ferr !== 1'b0)    begin errors++; $display("FAIL rx_rearm_ferr got %b exp 0", if0.ferr); end
  endtask

  task automatic test_rx_false_start;
    int n0;
    n0 = n_drx0;
    @(negedge clk);
    rx_line = 1'b0;
    repeat (30) @(negedge clk);
    rx_line = 1'b1;
    repeat (1200) @(negedge clk);
    checks++; if (n_drx0 - n0 !== 0)    begin errors++; $display("FAIL rx_false_start_count got %0d exp 0", n_drx0 - n0); end
    checks++; if (if0.doutrx !== 8'h81) begin errors++; $display("FAIL rx_false_start_data got %h exp 81", if0.doutrx); end
  endtask

  task automatic test_rx_parity;
    int n1;
    n1 = n_drx1;
    send_rx({1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    checks++; if (n_drx1 - n1 !== 1)    begin errors++; $display("FAIL rx_par_bad_count got %0d exp 1", n_drx1 - n1); end
    checks++; if (if1.perr !== 1'b1)    begin errors++; $display("FAIL rx_par_bad_perr got %b exp 1", if1.perr); end
    checks++; if (if1.doutrx !== 8'h3C) begin errors++; $display("FAIL rx_par_bad_data got %h exp 3c", if1.doutrx); end
    checks++; if (if1.ferr !== 1'b0)    begin errors++; $display("FAIL rx_par_bad_ferr got %b exp 0", if1.ferr); end
    checks++; if (if0.perr !== 1'b0)    begin errors++; $display("FAIL rx_nopar_perr got %b exp 0", if0.perr); end
    send_rx({1'b1, 1'b1, 8'h07, 1'b0}, 11);
    checks++; if (if1.perr !== 1'b0)    begin errors++; $display("FAIL rx_par_even_ok got %b exp 0", if1.perr); end
    checks++; if (if1.doutrx !== 8'h07) begin errors++; $display("FAIL rx_par_even_data got %h exp 07", if1.doutrx); end
    checks++; if (if2.perr !== 1'b1)    begin errors++; $display("FAIL rx_par_odd_bad got %b exp 1", if2.perr); end
  endtask

  initial begin
    test_reset;
    test_tx_8n1;
    test_tx_parity;
    test_tx_busy_ignore;
    test_reset_midframe;
    test_rx_8n1;
    test_rx_framing;
    test_rx_false_start;
    test_rx_parity;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_xcvr.md
UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 CLK_FREQ, default 1000000, system clock frequency in Hz.
REQ-002 BAUD_RATE, default 9600, line bit rate in bit/s.
REQ-003 DATA_BITS, default 8, payload width; legal range 5..8.
REQ-004 PARITY, default 0, parity mode: 0 none, 1 even, 2 odd; value 3 is illegal.
REQ-005 STOP_BITS, default 1, stop bits sent by TX: 1 or 2.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's responsibility.
REQ-008 rx  in  1  serial receive line; idles high; asynchronous to clk.
REQ-009 dintx  in  DATA_BITS  TX payload; sampled only on the accepting cycle.
REQ-010 newd  in  1  TX request; level-sensitive.
REQ-011 tx  out  1  serial transmit line; idles high.
REQ-012 doutrx  out  DATA_BITS  last received payload; held until the next donerx.
REQ-013 donetx  out  1  one-cycle pulse at the end of the last TX stop bit.
REQ-014 donerx  out  1  one-cycle pulse when doutrx, perr and ferr update.
REQ-015 tx_busy  out  1  high from the accepting cycle through the donetx cycle.
REQ-016 perr  out  1  parity error of the frame flagged by the latest donerx.
REQ-017 ferr  out  1  framing error (stop bit sampled 0) of the frame flagged by the latest donerx.

Function
REQ-018 The design SHALL compute DIV = CLK_FREQ/(BAUD_RATE*16), truncated. One oversample tick = DIV clocks; one bit period = 16 ticks. Defaults give DIV=6 and a 96-clock bit period.
REQ-019 An illegal DATA_BITS, PARITY or STOP_BITS value, or DIV<1, SHALL stop elaboration.
REQ-020 TX states: IDLE, START, DATA, PARITY, STOP.
 - The state sequence is IDLE->START->DATA->PARITY->STOP->IDLE.
 - PARITY is skipped when PARITY=0.
REQ-021 TX SHALL accept a request on any rising edge where newd=1 and tx_busy=0.
 - dintx is latched on that edge.
 - The TX bit counter restarts on that edge.
 - tx goes low on the next edge.
REQ-022 TX SHALL send bits LSB first, one bit period each.
 - Parity bit: XOR of the payload (even mode) or its inverse (odd mode).
 - Stop bits: STOP_BITS periods of tx=1.
REQ-023 donetx SHALL pulse on the final clock of the last stop period. tx_busy SHALL fall on the following edge.
 - If newd=1 on the edge after donetx, the next start bit follows with no idle gap beyond that cycle.
REQ-024 newd=1 while tx_busy=1 SHALL be ignored. It SHALL NOT be queued.
REQ-025 rx SHALL pass through a two-flop synchroniser before any use.
REQ-026 RX states: IDLE, START, DATA, PARITY, STOP.
 - IDLE->START on a synchronised falling edge of rx; the tick counter restarts there.
REQ-027 RX SHALL resample in START at tick 8 (mid-bit).
 - rx=1 at that sample means a false start: return to IDLE with no donerx.
REQ-028 RX SHALL sample every DATA, PARITY and STOP bit at its tick 8 and shift data LSB first.
REQ-029 RX SHALL check exactly one stop bit regardless of STOP_BITS.
REQ-030 On the stop-bit sample, RX SHALL update doutrx, perr and ferr, pulse donerx for one cycle, and return to IDLE.
 - perr=0 whenever PARITY=0.
 - When ferr=1, RX SHALL wait for rx=1 before re-arming start detection.
REQ-031 TX and RX SHALL operate independently and concurrently.
 - donetx and donerx may assert in the same cycle.

Reset
REQ-032 While rst=0, the outputs SHALL be: tx=1, tx_busy=0, donetx=0, donerx=0, doutrx=0, perr=0, ferr=0.
 - Both FSMs in IDLE; all counters 0; synchroniser flops 1.
REQ-033 Reset asserted mid-frame SHALL abort both directions immediately. No done pulse SHALL be issued for the aborted frame.

Verification
REQ-034 8N1 defaults, dintx=0xA5, newd=1 for 1 cycle:
 - tx low 96 clocks, then bits 1,0,1,0,0,1,0,1 at 96 clocks each, then high.
 - donetx exactly 960 clocks after acceptance.
REQ-035 PARITY=1, dintx=0x07:
 - Parity bit =1.
 - With PARITY=2, same data: parity bit =0.
 - Frame length 11 bit periods.
REQ-036 RX, 8N1: drive a frame of 0x3C at 96 clocks per bit -> one donerx, doutrx=0x3C, perr=0, ferr=0.
 - Repeat with the stop bit driven 0 -> donerx with ferr=1.
REQ-037 RX false start and parity error:
 - rx low for 30 clocks, then high -> no donerx.
 - PARITY=1 with the parity bit flipped -> donerx with perr=1.
REQ-038 Busy and reset behaviour:
 - newd pulsed mid-frame -> no second frame.
 - rst=0 at bit 4 of a TX frame -> tx=1 and tx_busy=0 within the same cycle; no donetx.
